// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: store-size encodings,
// default address window, store-buffer entry layout and lane helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_BYTE = 2'b01,
        WR_HALF = 2'b10,
        WR_WORD = 2'b11
    } wr_en_e;

    localparam logic [15:0] BASE_HI_DEFAULT = 16'h1001;

    // Word index is ADDR[15:2] regardless of DEPTH_WORDS.
    localparam int IDX_W = 14;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [3:0]       mask;
        logic [31:0]      data;
    } sb_entry_t;

    // A store is naturally aligned when its low address bits fit its size.
    function automatic logic is_aligned(input wr_en_e wr, input logic [1:0] lo);
        case (wr)
            WR_HALF: return ~lo[0];
            WR_WORD: return (lo == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Byte-enable mask for the lanes a store touches.
    function automatic logic [3:0] lane_mask(input wr_en_e wr, input logic [1:0] lo);
        case (wr)
            WR_BYTE: return 4'b0001 << lo;
            WR_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            WR_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Move right-aligned store data into its byte lanes.
    function automatic logic [31:0] lane_data(input wr_en_e wr, input logic [1:0] lo,
                                              input logic [31:0] din);
        case (wr)
            WR_BYTE: return {24'h0, din[7:0]} << {lo, 3'b000};
            WR_HALF: return lo[1] ? {din[15:0], 16'h0} : {16'h0, din[15:0]};
            WR_WORD: return din;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_store_buf.sv
// One-entry store buffer: captures accepted stores, drains the previous
// entry to storage on the next edge, and forwards pending bytes to reads.
module dmem_store_buf
    import dmem_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  sb_entry_t        i_cap,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [31:0]      i_mem_word,
    output logic [31:0]      o_rd_data,
    output sb_entry_t        o_drain
);

    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_mask;
    logic [31:0]      r_data;
    logic             w_fwd;

    // Valid follows the incoming accept each edge: new entry replaces the
    // drained one, otherwise the buffer empties. Reset discards any entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_cap.valid;
        end
    end

    // Entry payload only needs loading on an accepted store.
    always_ff @(posedge i_clk) begin
        if (i_cap.valid) begin
            r_idx  <= i_cap.idx;
            r_mask <= i_cap.mask;
            r_data <= i_cap.data;
        end
    end

    assign o_drain = {r_valid, r_idx, r_mask, r_data};

    // Pending bytes override storage so a read sees a store the cycle after issue.
    always_comb begin
        w_fwd = r_valid && (r_idx == i_rd_idx);
        o_rd_data = i_mem_word;
        for (int b = 0; b < 4; b++) begin
            if (w_fwd && r_mask[b]) begin
                o_rd_data[8*b +: 8] = r_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: address decode, alignment check, word storage and
// rejected-store error pulse. Optional macro DMEM_ERR_CNT_EN adds a
// saturating ERR_CNT output counting error pulses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [15:0] BASE_HI     = BASE_HI_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    input  logic [1:0]  WR_EN,
    output logic [31:0] DATA_OUT,
    output logic        ERR
`ifdef DMEM_ERR_CNT_EN
    ,
    output logic [15:0] ERR_CNT
`endif
);

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic             r_err;
    logic [IDX_W-1:0] w_idx;
    logic             w_sel;
    wr_en_e           w_wr;
    logic             w_store;
    logic             w_accept;
    logic             w_reject;
    sb_entry_t        w_cap;
    sb_entry_t        w_drain;
    logic [31:0]      w_mem_word;
    logic [31:0]      w_merged;

    assign w_idx    = ADDR[15:2];
    assign w_sel    = (ADDR[31:16] == BASE_HI) && ({18'h0, w_idx} < DEPTH_WORDS);
    assign w_wr     = wr_en_e'(WR_EN);
    assign w_store  = (w_wr != WR_NONE);
    assign w_accept = w_store && w_sel && is_aligned(w_wr, ADDR[1:0]);
    assign w_reject = w_store && !w_accept;

    // Build the buffer entry for the store presented this cycle.
    always_comb begin
        w_cap.valid = w_accept;
        w_cap.idx   = w_idx;
        w_cap.mask  = lane_mask(w_wr, ADDR[1:0]);
        w_cap.data  = lane_data(w_wr, ADDR[1:0], DATA_IN);
    end

    dmem_store_buf u_store_buf (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_cap      (w_cap),
        .i_rd_idx   (w_idx),
        .i_mem_word (w_mem_word),
        .o_rd_data  (w_merged),
        .o_drain    (w_drain)
    );

    // Storage is never reset; only drained buffer bytes are written.
    always_ff @(posedge CLK) begin
        if (w_drain.valid) begin
            for (int b = 0; b < 4; b++) begin
                if (w_drain.mask[b]) begin
                    r_mem[w_drain.idx][8*b +: 8] <= w_drain.data[8*b +: 8];
                end
            end
        end
    end

    assign w_mem_word = r_mem[w_idx];
    assign DATA_OUT   = w_sel ? w_merged : 32'h0;

    // One-cycle error pulse for a dropped store.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

    assign ERR = r_err;

`ifdef DMEM_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Count error pulses, holding at the maximum.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_err_cnt <= 16'h0;
        end else if (r_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'h1;
        end
    end

    assign ERR_CNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// stores/reads compared with a byte-addressed memory model.
module tb_dmem_responder;

    localparam logic [15:0] HI = 16'h1001;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] ADDR = 32'h0;
    logic [31:0] DATA_IN = 32'h0;
    logic [1:0]  WR_EN = 2'b00;
    logic [31:0] DATA_OUT;
    logic        ERR;
`ifdef DMEM_ERR_CNT_EN
    logic [15:0] ERR_CNT;
`endif

    dmem_responder dut (
        .CLK      (CLK),
        .RST      (RST),
        .ADDR     (ADDR),
        .DATA_IN  (DATA_IN),
        .WR_EN    (WR_EN),
        .DATA_OUT (DATA_OUT),
        .ERR      (ERR)
`ifdef DMEM_ERR_CNT_EN
        ,
        .ERR_CNT  (ERR_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_miss = 0;
    byte unsigned mbytes [65536];
    bit          exp_err = 1'b0;
    bit          undo_v = 1'b0;
    int          undo_base = 0;
    byte unsigned undo_b [4];
    int unsigned exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit sel_f(input logic [31:0] a);
        return (a[31:16] == HI) && (int'(a[15:2]) < 16384);
    endfunction

    function automatic int size_f(input logic [1:0] w);
        case (w)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit accept_f(input logic [31:0] a, input logic [1:0] w);
        int n;
        n = size_f(w);
        if (n == 0) return 1'b0;
        return sel_f(a) && ((int'(a[15:0]) % n) == 0);
    endfunction

    function automatic logic [31:0] read_f(input logic [31:0] a);
        int base;
        if (!sel_f(a)) return 32'h0;
        base = int'(a[15:0]) & 32'hFFFC;
        return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
    endfunction

    // One clock cycle: present inputs, check outputs, advance the model on the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        int base;
        int off;
        ADDR = a;
        DATA_IN = d;
        WR_EN = w;
        #1;
        check("rdata", DATA_OUT, read_f(a));
        check("err", {31'h0, ERR}, {31'h0, exp_err});
`ifdef DMEM_ERR_CNT_EN
        check("errcnt", {16'h0, ERR_CNT}, exp_cnt);
`endif
        @(posedge CLK);
        if (RST) begin
            if (exp_err && exp_cnt != 32'hFFFF) exp_cnt++;
            undo_v = 1'b0;
            if (accept_f(a, w)) begin
                base = int'(a[15:0]) & 32'hFFFC;
                undo_v = 1'b1;
                undo_base = base;
                for (int i = 0; i < 4; i++) undo_b[i] = mbytes[base+i];
                off = int'(a[15:0]);
                for (int i = 0; i < size_f(w); i++) mbytes[off+i] = d[8*i +: 8];
            end
            exp_err = (w != 2'b00) && !accept_f(a, w);
        end
        @(negedge CLK);
    endtask

    // Read-only look at a fixed expected value, without an edge.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ADDR = a;
        WR_EN = 2'b00;
        #1;
        check(tag, DATA_OUT, exp);
    endtask

    // Assert reset; the store still pending from the last edge never lands.
    task automatic do_reset(input int cycles);
        RST = 1'b0;
        if (undo_v) begin
            for (int i = 0; i < 4; i++) mbytes[undo_base+i] = undo_b[i];
        end
        undo_v = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;
        #1;
        check("rst_err", {31'h0, ERR}, 32'h0);
        for (int c = 0; c < cycles; c++) begin
            step({HI, 16'h0040}, $urandom, 2'b11);
        end
        RST = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  w;
        int          r;

        for (int i = 0; i < 65536; i++) mbytes[i] = 8'h00;

        #1;
        check("init_err", {31'h0, ERR}, 32'h0);
`ifdef DMEM_ERR_CNT_EN
        check("init_cnt", {16'h0, ERR_CNT}, 32'h0);
`endif
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // Known contents for every word the bench reads.
        step(32'h1001_0000, 32'h0BAD_F00D, 2'b11);
        step(32'h1001_0020, 32'h1122_3344, 2'b11);
        for (int i = 0; i < 8; i++) step(32'h1001_0040 + 32'(4*i), $urandom, 2'b11);

        // Forwarded read, then read from storage.
        step(32'h1001_0008, 32'hDEAD_BEEF, 2'b11);
        peek("sw_fwd", 32'h1001_0008, 32'hDEAD_BEEF);
        step(32'h1001_0008, 32'h0, 2'b00);
        step(32'h1001_0008, 32'h0, 2'b00);
        step(32'h1001_0008, 32'h0, 2'b00);
        peek("sw_mem", 32'h1001_0008, 32'hDEAD_BEEF);

        // Back-to-back partial stores merging into one word.
        step(32'h1001_0010, 32'h0, 2'b11);
        step(32'h1001_0011, 32'hFFFF_FFAA, 2'b01);
        step(32'h1001_0012, 32'hFFFF_1234, 2'b10);
        peek("merge_fwd", 32'h1001_0010, 32'h1234_AA00);
        step(32'h1001_0010, 32'h0, 2'b00);
        step(32'h1001_0010, 32'h0, 2'b00);
        peek("merge_mem", 32'h1001_0010, 32'h1234_AA00);

        // Rejected stores.
        step(32'h1001_0001, 32'h0000_5678, 2'b10);
        #1 check("mis_err_hi", {31'h0, ERR}, 32'h1);
        step(32'h1001_0000, 32'h0, 2'b00);
        #1 check("mis_err_lo", {31'h0, ERR}, 32'h0);
        peek("mis_unchanged", 32'h1001_0000, 32'h0BAD_F00D);
        step(32'h0040_0000, 32'hCAFE_CAFE, 2'b11);
        peek("oow_zero", 32'h0040_0000, 32'h0);
        #1 check("oow_err", {31'h0, ERR}, 32'h1);
        step(32'h1001_0000, 32'h0, 2'b00);

        // Reset before drain discards the pending store.
        step(32'h1001_0020, 32'h0000_0055, 2'b11);
        do_reset(2);
        peek("rst_discard", 32'h1001_0020, 32'h1122_3344);
        check("rst_err_after", {31'h0, ERR}, 32'h0);
        step(32'h1001_0020, 32'h0, 2'b00);

`ifdef DMEM_ERR_CNT_EN
        // Counter counts pulses and saturates.
        do_reset(1);
        step(32'h1001_0002, 32'h1, 2'b11);
        step(32'h1001_0003, 32'h1, 2'b10);
        step(32'h1001_0005, 32'h1, 2'b11);
        step(32'h1001_0000, 32'h0, 2'b00);
        step(32'h1001_0000, 32'h0, 2'b00);
        #1 check("cnt_three", {16'h0, ERR_CNT}, 32'd3);
        force dut.r_err_cnt = 16'hFFFE;
        #1;
        release dut.r_err_cnt;
        exp_cnt = 32'hFFFE;
        step(32'h1001_0001, 32'h1, 2'b11);
        step(32'h1001_0001, 32'h1, 2'b10);
        step(32'h1001_0000, 32'h0, 2'b00);
        step(32'h1001_0000, 32'h0, 2'b00);
        #1 check("cnt_sat", {16'h0, ERR_CNT}, 32'hFFFF);
        step(32'h1001_0003, 32'h1, 2'b11);
        step(32'h1001_0000, 32'h0, 2'b00);
        step(32'h1001_0000, 32'h0, 2'b00);
`endif

        // Random traffic in a small window plus occasional outside hits.
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85) a = {HI, 16'h0040 + 16'($urandom_range(0, 31))};
            else if (r < 92) a = {16'h0040, 16'($urandom)};
            else a = {HI ^ 16'h0001, 16'h0040 + 16'($urandom_range(0, 31))};
            w = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 2)));
            else step(a, $urandom, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
